// File: rtl/n64_resp_rx_pkg.sv
// Shared N64 reply-receiver constants and FSM state encoding.
// The bit timing constants are also used by the command generator.
package n64_resp_rx_pkg;

    localparam int N64_BIT_US    = 4;
    localparam int N64_RESP_BITS = 32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FALL = 3'd1,
        S_SAMPLE    = 3'd2,
        S_WAIT_RISE = 3'd3,
        S_WAIT_STOP = 3'd4,
        S_STOP_HI   = 3'd5,
        S_DONE      = 3'd6,
        S_TIMEOUT   = 3'd7
    } state_t;

endpackage

// File: rtl/n64_line_sync.sv
// Two-flop synchronizer for the open-drain N64 data line, with registered
// one-cycle fall/rise pulses derived from the synchronized copy.
module n64_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic fall,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_fall;
    logic r_rise;

    // Line flops reset high so an idle bus produces no spurious edge after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_fall <= r_prev & ~r_sync;
            r_rise <= ~r_prev & r_sync;
        end
    end

    assign q    = r_sync;
    assign fall = r_fall;
    assign rise = r_rise;

endmodule

// File: rtl/n64_resp_rx.sv
// Receives the N64 controller reply (NBITS data bits + stop bit), decoding each
// bit by sampling the line 2us after its falling edge.
module n64_resp_rx
    import n64_resp_rx_pkg::*;
#(
    parameter int CLKS_PER_US = 12,
    parameter int NBITS       = N64_RESP_BITS,
    parameter int TIMEOUT_US  = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             din,
    output logic             busy,
    output logic [NBITS-1:0] data,
    output logic             valid,
    output logic             timeout
);

    localparam int TMO_MAX  = TIMEOUT_US * CLKS_PER_US;
    localparam int TMO_W    = $clog2(TMO_MAX + 1);
    localparam int SMP_LAST = 2 * CLKS_PER_US - 1;
    localparam int SMP_W    = $clog2(2 * CLKS_PER_US);
    localparam int BIT_W    = $clog2(NBITS);

    logic [1:0]       r_rst_sync;
    logic             w_rst;
    logic             w_q;
    logic             w_fall;
    logic             w_rise;
    state_t           r_state;
    state_t           w_next;
    logic [TMO_W-1:0] r_tmo;
    logic [SMP_W-1:0] r_smp;
    logic [BIT_W-1:0] r_bit;
    logic [NBITS-1:0] r_shreg;
    logic [NBITS-1:0] r_data;
    logic             r_valid;
    logic             r_timeout;
    logic             w_tmo_exp;
    logic             w_smp_pt;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    n64_line_sync u_line_sync (
        .clk   (clk),
        .reset (w_rst),
        .din   (din),
        .q     (w_q),
        .fall  (w_fall),
        .rise  (w_rise)
    );

    assign w_tmo_exp = (r_tmo >= TMO_W'(TMO_MAX));
    assign w_smp_pt  = (r_smp == SMP_W'(SMP_LAST));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm) w_next = S_WAIT_FALL;
            end
            S_WAIT_FALL: begin
                if (w_fall)         w_next = S_SAMPLE;
                else if (w_tmo_exp) w_next = S_TIMEOUT;
            end
            S_SAMPLE: begin
                if (w_smp_pt) w_next = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (w_q || w_rise) begin
                    w_next = (r_bit == BIT_W'(NBITS - 1)) ? S_WAIT_STOP : S_WAIT_FALL;
                end else if (w_tmo_exp) begin
                    w_next = S_TIMEOUT;
                end
            end
            S_WAIT_STOP: begin
                if (w_fall)         w_next = S_STOP_HI;
                else if (w_tmo_exp) w_next = S_TIMEOUT;
            end
            S_STOP_HI: begin
                if (w_q)            w_next = S_DONE;
                else if (w_tmo_exp) w_next = S_TIMEOUT;
            end
            S_DONE:    w_next = S_IDLE;
            S_TIMEOUT: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_state   <= S_IDLE;
            r_tmo     <= '0;
            r_smp     <= '0;
            r_bit     <= '0;
            r_shreg   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;

            // Timeout counter restarts on every state change and saturates otherwise.
            if (w_next != r_state) begin
                r_tmo <= '0;
            end else if (r_tmo != '1) begin
                r_tmo <= r_tmo + TMO_W'(1);
            end

            if (r_state == S_WAIT_FALL && w_next == S_SAMPLE) begin
                r_smp <= '0;
            end else if (r_state == S_SAMPLE) begin
                r_smp <= r_smp + SMP_W'(1);
            end

            if (r_state == S_IDLE && arm) begin
                r_bit <= '0;
            end else if (r_state == S_WAIT_RISE && w_next == S_WAIT_FALL) begin
                r_bit <= r_bit + BIT_W'(1);
            end

            if (r_state == S_SAMPLE && w_smp_pt) begin
                r_shreg <= {r_shreg[NBITS-2:0], w_q};
            end

            // Data and its strobe land in the same cycle.
            if (w_next == S_DONE) begin
                r_data <= r_shreg;
            end
            r_valid   <= (w_next == S_DONE);
            r_timeout <= (w_next == S_TIMEOUT);
        end
    end

    assign busy    = (r_state inside {S_WAIT_FALL, S_SAMPLE, S_WAIT_RISE, S_WAIT_STOP, S_STOP_HI});
    assign data    = r_data;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_n64_resp_rx.sv
// Directed bench for n64_resp_rx: a line BFM drives controller replies while a
// monitor pops expected events from a scoreboard queue.
`timescale 1ns/1ps
module tb_n64_resp_rx;

    typedef struct {
        bit          is_tmo;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        arm = 1'b0;
    logic        din = 1'b1;
    logic        busy;
    logic [31:0] data;
    logic        valid;
    logic        timeout;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    int          n_tmo = 0;
    int          cyc = 0;
    int          tmo_cyc = 0;
    int          arm_cyc = 0;
    logic [31:0] model_data = 32'h0;

    n64_resp_rx #(.CLKS_PER_US(12), .NBITS(32), .TIMEOUT_US(100)) dut (
        .clk     (clk),
        .reset   (reset),
        .arm     (arm),
        .din     (din),
        .busy    (busy),
        .data    (data),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Monitor: every valid/timeout strobe must match the head of the scoreboard.
    initial begin
        bit   chk_busy;
        exp_t e;
        chk_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_busy) begin
                check("busy_after_valid", {31'b0, busy}, 32'h0);
                chk_busy = 1'b0;
            end
            if (valid === 1'b1 || timeout === 1'b1) begin
                check("valid_and_timeout_exclusive", {31'b0, valid & timeout}, 32'h0);
                if (sb.size() == 0) begin
                    check("unexpected_event", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check("event_kind_timeout", {31'b0, timeout}, {31'b0, e.is_tmo});
                    check("event_data", data, e.data);
                end
                if (valid === 1'b1) begin
                    n_valid++;
                    chk_busy = 1'b1;
                end else begin
                    n_tmo++;
                    tmo_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        arm_cyc = cyc;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic push_valid(input logic [31:0] w);
        exp_t e;
        e.is_tmo = 1'b0;
        e.data   = w;
        model_data = w;
        sb.push_back(e);
    endtask

    task automatic push_tmo();
        exp_t e;
        e.is_tmo = 1'b1;
        e.data   = model_data;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input bit jit, input bit spam);
        int lo;
        int hi;
        int j;
        lo = b ? 12 : 36;
        hi = b ? 36 : 12;
        if (jit) begin
            j  = int'($urandom_range(0, 2)) - 1;
            lo = lo + j;
            hi = hi - j + int'($urandom_range(0, 1));
        end
        din = 1'b0;
        tick(lo);
        din = 1'b1;
        if (spam) begin
            pulse_arm();
            tick(hi - 1);
        end else begin
            tick(hi);
        end
    endtask

    task automatic send_bits(input logic [31:0] w, input int n, input bit jit, input bit spam);
        for (int i = 31; i > 31 - n; i--) send_bit(w[i], jit, spam);
    endtask

    task automatic send_word(input logic [31:0] w, input bit jit, input bit spam);
        send_bits(w, 32, jit, spam);
        din = 1'b0;
        tick(12);
        din = 1'b1;
        tick(36);
        tick(10);
    endtask

    // Wait for the next valid or timeout strobe, bounded by max_cyc clocks.
    task automatic wait_evt(input string tag, input int max_cyc);
        int base;
        int k;
        base = n_valid + n_tmo;
        k = 0;
        while ((n_valid + n_tmo) == base && k < max_cyc) begin
            tick(1);
            k++;
        end
        check(tag, {31'b0, (n_valid + n_tmo) != base}, 32'h1);
    endtask

    initial begin
        int nv;
        int elapsed;
        logic [31:0] rw;

        // Reset state
        #2 reset = 1'b1;
        tick(5);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_valid", {31'b0, valid}, 32'h0);
        check("rst_timeout", {31'b0, timeout}, 32'h0);
        check("rst_data", data, 32'h0);
        reset = 1'b0;
        tick(5);

        // Long idle with no arm
        tick(5000);
        check("idle_busy", {31'b0, busy}, 32'h0);
        check("idle_data", data, 32'h0);
        check("idle_events", n_valid + n_tmo, 32'h0);

        // Basic reply
        pulse_arm();
        tick(2);
        check("armed_busy", {31'b0, busy}, 32'h1);
        tick(118);
        push_valid(32'h8000_0001);
        nv = n_valid;
        send_word(32'h8000_0001, 1'b0, 1'b0);
        check("reply1_count", n_valid - nv, 32'h1);
        check("reply1_data", data, 32'h8000_0001);

        // No reply: timeout after 100us
        push_tmo();
        pulse_arm();
        wait_evt("wait_timeout1", 1500);
        elapsed = tmo_cyc - arm_cyc;
        check("timeout_latency_in_range", {31'b0, (elapsed >= 1200 && elapsed <= 1204)}, 32'h1);
        check("timeout_keeps_data", data, 32'h8000_0001);
        tick(2);
        check("timeout_busy", {31'b0, busy}, 32'h0);

        // Reply stalls low after bit 15
        pulse_arm();
        tick(120);
        push_tmo();
        send_bits(32'h1234_5678, 16, 1'b0, 1'b0);
        din = 1'b0;
        wait_evt("wait_timeout_stall", 1500);
        din = 1'b1;
        check("stall_keeps_data", data, 32'h8000_0001);
        tick(50);
        pulse_arm();
        tick(120);
        push_valid(32'hA5A5_5A5A);
        nv = n_valid;
        send_word(32'hA5A5_5A5A, 1'b0, 1'b0);
        check("reply_a5_count", n_valid - nv, 32'h1);

        // Reset in the middle of bit 20
        pulse_arm();
        tick(120);
        send_bits(32'h0F0F_F0F0, 20, 1'b0, 1'b0);
        din = 1'b0;
        tick(10);
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_data", data, 32'h0);
        model_data = 32'h0;
        tick(3);
        din = 1'b1;
        reset = 1'b0;
        tick(10);
        pulse_arm();
        tick(120);
        push_valid(32'hFFFF_FFFF);
        nv = n_valid;
        send_word(32'hFFFF_FFFF, 1'b1, 1'b0);
        check("reply_ff_count", n_valid - nv, 32'h1);

        // Repeated arm during a jittered reply, all-zero and random words
        pulse_arm();
        tick(120);
        push_valid(32'h0000_0000);
        nv = n_valid;
        send_word(32'h0000_0000, 1'b1, 1'b1);
        check("reply_zero_count", n_valid - nv, 32'h1);
        rw = $urandom;
        pulse_arm();
        tick(120);
        push_valid(rw);
        nv = n_valid;
        send_word(rw, 1'b1, 1'b1);
        check("reply_rand_count", n_valid - nv, 32'h1);
        check("reply_rand_data", data, rw);

        tick(20);
        check("scoreboard_empty", sb.size(), 32'h0);
        check("total_valid", n_valid, 32'd5);
        check("total_timeout", n_tmo, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
